// File: rtl/poly_csubq_stream.sv
// poly_csubq_stream: maps 128 signed coefficient pairs to canonical [0, KYBER_Q) behind a
// 2-entry valid/ready buffer. Define POLY_CSUBQ_CHECK_EN to add the sticky range/index err port.
module poly_csubq_stream #(
    parameter int DEPTH   = 8,
    parameter int KYBER_Q = 3329
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_dout_1,
    input  logic [15:0]      in_dout_2,
    input  logic [DEPTH-1:0] in_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_coeff_1,
    output logic [11:0]      out_coeff_2,
    output logic [DEPTH-2:0] out_index,
    output logic             busy,
`ifdef POLY_CSUBQ_CHECK_EN
    output logic             err,
`endif
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    typedef struct packed {
        logic [11:0]      c1;
        logic [11:0]      c2;
        logic [DEPTH-2:0] idx;
    } entry_t;

    localparam logic signed [16:0] Q = 17'(KYBER_Q);

    function automatic logic [11:0] csubq(input logic [15:0] x);
        logic signed [16:0] xs;
        logic signed [16:0] t;
        logic signed [16:0] y;
        xs = {x[15], x};
        t  = xs + (xs[16] ? Q : 17'sd0);
        y  = t - ((t >= Q) ? Q : 17'sd0);
        return 12'(y);
    endfunction

    state_e           state_q;
    logic [DEPTH-2:0] cnt_q;
    logic [1:0]       occ_q;
    logic             wr_q;
    logic             rd_q;
    entry_t           mem_q [2];

    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           head;

    assign in_ready  = (state_q == RUN) && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = set & in_valid & in_ready;
    assign pop       = set & out_valid & out_ready;

    assign wr_entry  = '{c1: csubq(in_dout_1), c2: csubq(in_dout_2), idx: cnt_q};
    assign head      = out_valid ? mem_q[rd_q] : '0;

    assign out_coeff_1 = head.c1;
    assign out_coeff_2 = head.c2;
    assign out_index   = head.idx;
    assign busy        = (state_q == RUN) || (state_q == FLUSH);
    assign done        = (state_q == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            occ_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (set) begin
            if (push) begin
                mem_q[wr_q] <= wr_entry;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (push) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (&cnt_q) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                // Leave FLUSH only once the buffer has fully drained downstream.
                FLUSH: begin
                    if (occ_q == 2'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef POLY_CSUBQ_CHECK_EN
    localparam logic signed [16:0] QNEG = -Q;
    localparam logic signed [16:0] Q2   = 17'(2 * KYBER_Q);

    function automatic logic out_of_range(input logic [15:0] x);
        logic signed [16:0] xs;
        xs = {x[15], x};
        return (xs < QNEG) || (xs >= Q2);
    endfunction

    logic err_q;
    logic bad_d;

    assign bad_d = out_of_range(in_dout_1) || out_of_range(in_dout_2) ||
                   (in_index != {cnt_q, 1'b0});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (set) begin
            if ((state_q == IDLE) && start) begin
                err_q <= 1'b0;
            end else if (push && bad_d) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_index;
    assign unused_index = ^in_index;
`endif

endmodule

// File: tb/tb_poly_csubq_stream.sv
// tb_poly_csubq_stream: scoreboard bench for poly_csubq_stream; expected pairs are queued on
// accept and compared on every output transfer. Build with POLY_CSUBQ_CHECK_EN to cover err.
module tb_poly_csubq_stream;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        reset;
    logic        set;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_dout_1;
    logic [15:0] in_dout_2;
    logic [7:0]  in_index;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_coeff_1;
    logic [11:0] out_coeff_2;
    logic [6:0]  out_index;
    logic        busy;
    logic        done;
`ifdef POLY_CSUBQ_CHECK_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    poly_csubq_stream #(.DEPTH(8), .KYBER_Q(3329)) dut (
        .clk         (clk),
        .reset       (reset),
        .set         (set),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dout_1   (in_dout_1),
        .in_dout_2   (in_dout_2),
        .in_index    (in_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_coeff_1 (out_coeff_1),
        .out_coeff_2 (out_coeff_2),
        .out_index   (out_index),
        .busy        (busy),
`ifdef POLY_CSUBQ_CHECK_EN
        .err         (err),
`endif
        .done        (done)
    );

    typedef struct {
        int c1;
        int c2;
        int idx;
        bit dc1;
        bit dc2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_fire_cyc = 0;
    int din1 [128];
    int din2 [128];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int canon(input int x);
        int r;
        r = x % Q;
        if (r < 0) r += Q;
        return r;
    endfunction

    function automatic int sx(input logic [15:0] v);
        return int'(signed'(v));
    endfunction

    function automatic bit illegal(input int x);
        return (x < -Q) || (x >= 2 * Q);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop/compare on output transfers, then push on input accepts.
    always @(negedge clk) begin
        if (reset && set && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_index", int'(out_index), mon_e.idx);
                if (!mon_e.dc1) check("out_coeff_1", int'(out_coeff_1), mon_e.c1);
                if (!mon_e.dc2) check("out_coeff_2", int'(out_coeff_2), mon_e.c2);
            end
            pop_cnt++;
        end
        if (reset && set && in_valid && in_ready) begin
            mon_e.c1  = canon(sx(in_dout_1));
            mon_e.c2  = canon(sx(in_dout_2));
            mon_e.dc1 = illegal(sx(in_dout_1));
            mon_e.dc2 = illegal(sx(in_dout_2));
            mon_e.idx = acc_cnt;
            sb.push_back(mon_e);
            acc_cnt++;
        end
        if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
        end
        if (in_ready) rdy_cnt++;
    end

    task automatic fill_random();
        for (int i = 0; i < 128; i++) begin
            din1[i] = int'($urandom_range(0, 3 * Q - 1)) - Q;
            din2[i] = int'($urandom_range(0, 3 * Q - 1)) - Q;
        end
    endtask

    task automatic drive_pair(input int p, input int bad_idx_pair);
        in_dout_1 = 16'(din1[p]);
        in_dout_2 = 16'(din2[p]);
        in_index  = (p == bad_idx_pair) ? 8'd18 : 8'(2 * p);
    endtask

    task automatic start_run();
        acc_cnt  = 0;
        pop_cnt  = 0;
        rdy_cnt  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic abort_run();
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_full_valid", int'(out_valid), 1);
        check("abort_full_ready", int'(in_ready), 0);
        reset = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_in_ready", int'(in_ready), 0);
        check("rst_mid_coeff_1", int'(out_coeff_1), 0);
        check("rst_mid_coeff_2", int'(out_coeff_2), 0);
        check("rst_mid_index", int'(out_index), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        sb.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic stream(input int stall_pair, input int freeze_pair, input int abort_pair,
                          input int bad_idx_pair, input int err_pair, input bit gaps);
        int pair = 0;
        int budget = 0;
        int stall_left = 0;
        int frz_left = 0;
        bit fire;
        bit chk_err = 1'b0;
        drive_pair(0, bad_idx_pair);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set       = 1'b1;
        while (pair < 128 && budget < 3000) begin
            @(negedge clk);
            if (stall_left > 0 && stall_left <= 3) begin
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_out_valid", int'(out_valid), 1);
                if (sb.size() > 0) check("stall_head_index", int'(out_index), sb[0].idx);
            end
            if (frz_left > 0 && frz_left <= 3) begin
                check("freeze_busy", int'(busy), 1);
                check("freeze_done", int'(done), 0);
            end
`ifdef POLY_CSUBQ_CHECK_EN
            if (chk_err) begin
                check("err_set", int'(err), 1);
                chk_err = 1'b0;
            end else if (err_pair >= 0 && pair == err_pair) begin
                check("err_before", int'(err), 0);
            end
`endif
            fire = set && in_valid && in_ready;
            if (fire) last_fire_cyc = cyc;
            @(posedge clk); #1;
            budget++;
            if (stall_left > 0) stall_left--;
            if (frz_left > 0) frz_left--;
            if (fire) begin
                pair++;
                if (pair == err_pair + 1) chk_err = 1'b1;
                if (pair == stall_pair) stall_left = 5;
                if (pair == freeze_pair) frz_left = 4;
                if (pair == abort_pair) begin
                    abort_run();
                    return;
                end
                if (pair < 128) drive_pair(pair, bad_idx_pair);
            end
            in_valid  = (pair < 128) && (!gaps || $urandom_range(0, 3) != 0);
            out_ready = (stall_left == 0);
            start     = (frz_left == 4);
            set       = !(frz_left inside {[1:3]});
        end
        in_valid = 1'b0;
        start    = 1'b0;
        set      = 1'b1;
        if (pair < 128) check("stream_timeout", pair, 128);
    endtask

    task automatic finish_run(input bit chk_rdy);
        int w = 0;
        while (done_cnt == 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (done_cnt == 0) check("done_timeout", done_cnt, 1);
        else check("done_latency", done_cyc - last_fire_cyc, 3);
        repeat (4) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("idle_busy", int'(busy), 0);
        check("sb_drained", sb.size(), 0);
        check("pairs_out", pop_cnt, 128);
        if (chk_rdy) check("in_ready_cycles", rdy_cnt, 128);
    endtask

    initial begin
        reset     = 1'b0;
        set       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_dout_1 = '0;
        in_dout_2 = '0;
        in_index  = '0;
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_coeff_1", int'(out_coeff_1), 0);
        check("rst_coeff_2", int'(out_coeff_2), 0);
        check("rst_index", int'(out_index), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
`ifdef POLY_CSUBQ_CHECK_EN
        check("rst_err", int'(err), 0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;

        // Plain full-rate drain with the boundary coefficient pairs up front.
        fill_random();
        din1[0] = -5;   din2[0] = 3329;
        din1[1] = 3328; din2[1] = 6657;
        din1[2] = 0;    din2[2] = -3329;
        start_run();
        check("run_busy", int'(busy), 1);
        stream(-1, -1, -1, -1, -1, 1'b0);
        finish_run(1'b1);

        // Downstream stall mid-stream, then start pulse + clock-enable freeze.
        fill_random();
        start_run();
        stream(40, 90, -1, -1, -1, 1'b0);
        finish_run(1'b0);

        // Reset with a full buffer at pair 60; no done may follow.
        fill_random();
        start_run();
        stream(-1, -1, 60, -1, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_busy", int'(busy), 0);

        // Fresh drain after the abort, with irregular upstream valid.
        fill_random();
        start_run();
        stream(-1, -1, -1, -1, -1, 1'b1);
        finish_run(1'b0);

`ifdef POLY_CSUBQ_CHECK_EN
        fill_random();
        din1[10] = 7000;
        start_run();
        check("err_clear_start1", int'(err), 0);
        stream(-1, -1, -1, -1, 10, 1'b0);
        finish_run(1'b0);
        check("err_sticky_range", int'(err), 1);

        fill_random();
        start_run();
        check("err_clear_start2", int'(err), 0);
        stream(-1, -1, -1, 10, 10, 1'b0);
        finish_run(1'b0);
        check("err_sticky_index", int'(err), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_csubq_stream.md
Name: poly_csubq_stream

Overview:
- Downstream stage of the polyvec basemul-accumulate unit.
- Drains the accumulator's 128 Barrett-reduced signed coefficient pairs and maps each coefficient to canonical unsigned form in [0, q), q = 3329.
- Forwards the results through a 2-entry buffer with a valid/ready handshake to the packing/compress stage.
- Counts pairs, drops in_ready after the last one, and pulses done once the buffer has drained.

Parameters:
- DEPTH, 8, coefficient address width; a polynomial holds 2^DEPTH = 256 coefficients, i.e. 2^(DEPTH-1) = 128 pairs.
- KYBER_Q, 3329, modulus used for normalization.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- set  input  1  global clock enable; when low all state holds and no transfer occurs.
- start  input  1  one-cycle pulse; arms a new 128-pair drain. Ignored unless in IDLE.
- in_valid  input  1  upstream pair valid (accumulator done & readout).
- in_ready  output  1  block accepts a pair this cycle; drives the accumulator's readout.
- in_dout_1  input  16  signed coefficient 2i.
- in_dout_2  input  16  signed coefficient 2i+1.
- in_index  input  DEPTH  upstream coefficient index (even, 2i); used only by the optional feature.
- out_valid  output  1  output pair valid.
- out_ready  input  1  downstream accepts the pair.
- out_coeff_1  output  12  canonical coefficient 2i.
- out_coeff_2  output  12  canonical coefficient 2i+1.
- out_index  output  DEPTH-1  pair index i, 0..127.
- busy  output  1  high in RUN or FLUSH.
- done  output  1  one-cycle pulse at end of drain.

Behaviour:
- Reset (reset=0, async): state=IDLE, pair counter=0, FIFO empty, wr/rd pointers=0. Outputs: in_ready=0, out_valid=0, out_coeff_1/2=0, out_index=0, busy=0, done=0. Reset mid-drain discards all buffered data; no done is emitted.
- Accept: a pair is taken on a clk edge where set & in_valid & in_ready.
- Produce: a pair leaves on a clk edge where set & out_valid & out_ready.
- Normalization, per coefficient, on 17-bit signed arithmetic, combinational before the FIFO write:
  - t = x + (x<0 ? q : 0)
  - y = t - (t>=q ? q : 0)
  - Legal input range is -q <= x < 2q. Result is y[11:0]. Out-of-range input yields unspecified y.
- FIFO: 2 entries of {coeff_1, coeff_2, pair index}.
  - Written pair index = counter value at accept time.
  - out_* show the head entry; out_coeff/out_index read 0 when empty.
  - out_valid = (occupancy != 0).
- Latency: a pair accepted at edge n is visible on out_* with out_valid=1 after edge n (1 cycle). No combinational in->out path.
- in_ready = (state==RUN) & (occupancy<2). No pass-through when full.
- Simultaneous push and pop: occupancy unchanged; ordering preserved.
- FSM, all transitions qualified by set:
  - IDLE: start -> RUN, counter=0.
  - RUN: each accept increments counter. The accept of pair 127 -> FLUSH; counter wraps to 0 and is not used further.
  - FLUSH: in_ready=0; when occupancy==0 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- set=0: no accept, no pop, no state change. A done pulse already in DONE is held until set returns.
- Throughput: 1 pair/cycle when out_ready stays high.

Optional Feature:
- Macro: POLY_CSUBQ_CHECK_EN.
- Defined:
  - Adds output port err (1 bit), sticky, reset 0, cleared on the start accept.
  - err is set on any accept where either coefficient is outside [-q, 2q), or where in_index != 2*counter.
  - Data is still forwarded unchanged.
- Not defined:
  - The err port and the checking logic do not exist.
  - in_index is unused.

Test Plan:
- Reset, then start; stream 128 pairs with in_valid=1 and out_ready=1 -> in_ready high for 128 cycles, out_index runs 0..127 in order, done pulses exactly once, 2 cycles after the last accept.
- Inputs (-5, 3329), (3328, 6657), (0, -3329) -> outputs (3324, 0), (3328, 3328), (0, 0).
- out_ready=0 for 5 cycles mid-stream -> after 2 accepts in_ready=0, out_valid holds, head data stable; on release no pair is lost or duplicated.
- reset asserted at pair 60 while the FIFO is full -> all outputs 0 immediately; a later start drains a full 128 pairs from out_index 0.
- start pulsed during RUN, and set=0 for 3 cycles -> no state change, counters frozen, sequence completes normally.
- With POLY_CSUBQ_CHECK_EN defined: in_dout_1 = 7000 at pair 10 -> err=1 from the following cycle and stays set until the next start; in_index=18 at pair 10 also sets err.
